video_capture: RTL

Pixel-clock receive end of the video interface. Samples HS/VS/BLANK/RGB as produced by the display timing generator, recovers pixel coordinates, checks line and frame geometry, and emits a buffered stream of pixel writes (linear word index plus 24-bit RGB) for a downstream SDRAM writer. Sits between an external or looped-back video source and the Wishbone frame-store writer. The whole block runs in the pixel_clk domain.

---
 rtl/video_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 55 +++++
 rtl/video_capture.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared types and timing constants for the video capture path
package video_pkg;

    localparam int HDISP_NOM = 800;
    localparam int VDISP_NOM = 480;

    // Blanking geometry shared with the display timing generator
    localparam int HFP    = 40;
    localparam int HPULSE = 48;
    localparam int HBP    = 88;
    localparam int VFP    = 13;
    localparam int VPULSE = 3;
    localparam int VBP    = 32;

    localparam int CAP_ADDR_W = $clog2(HDISP_NOM * VDISP_NOM);

    typedef logic [23:0] pixel_t;

    typedef struct packed {
        logic [CAP_ADDR_W-1:0] addr;
        pixel_t                data;
        logic                  sof;
    } cap_entry_t;

    typedef enum logic {
        HUNT  = 1'b0,
        FRAME = 1'b1
    } cap_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, push and pop may coincide, asynchronous reset
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    // A pop in the same cycle frees the slot the push needs
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/video_capture.sv
// rtl/video_capture.sv - recovers pixel coordinates from sync/blank and streams pixel writes
module video_capture
    import video_pkg::*;
#(
    parameter int HDISP      = 800,
    parameter int VDISP      = 480,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                           pixel_clk,
    input  logic                           pixel_rst,
    input  logic                           vid_hs,
    input  logic                           vid_vs,
    input  logic                           vid_blank,
    input  logic [23:0]                    vid_rgb,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(HDISP*VDISP)-1:0] out_addr,
    output logic [23:0]                    out_data,
    output logic                           out_sof,
    input  logic                           clr_status,
    output logic [15:0]                    frame_cnt,
    output logic                           ovf_err,
    output logic                           line_err,
    output logic                           frame_err
);
    localparam int ADDR_W = $clog2(HDISP * VDISP);
    localparam int XW     = $clog2(HDISP + 1);
    localparam int YW     = $clog2(VDISP + 1);
    localparam int RW     = $clog2(HDISP + 2);

    localparam logic [XW-1:0]   X_MAX     = XW'(HDISP);
    localparam logic [YW-1:0]   Y_MAX     = YW'(VDISP);
    localparam logic [RW-1:0]   RUN_FULL  = RW'(HDISP);
    localparam logic [RW-1:0]   RUN_SAT   = RW'(HDISP + 1);
    localparam logic [ADDR_W:0] LINE_STEP = (ADDR_W+1)'(HDISP);

    logic       hs_s0;
    logic       vs_s0;
    logic       blank_s0;
    pixel_t     rgb_s0;
    logic       vs_prev;
    logic       blank_prev;

    cap_state_t      state;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [RW-1:0]   run_len;
    logic [ADDR_W:0] line_base;

    logic            vs_edge;
    logic            run_end;
    logic            in_frame;
    logic [XW-1:0]   cur_x;
    logic [YW-1:0]   cur_y;
    logic [ADDR_W:0] cur_base;
    logic [ADDR_W:0] cur_addr;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            ovf_set;
    logic            line_set;
    logic            frame_set;
    cap_entry_t      wr_entry;
    cap_entry_t      rd_entry;

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            hs_s0      <= 1'b1;
            vs_s0      <= 1'b1;
            blank_s0   <= 1'b0;
            rgb_s0     <= '0;
            vs_prev    <= 1'b1;
            blank_prev <= 1'b0;
        end else begin
            hs_s0      <= vid_hs;
            vs_s0      <= vid_vs;
            blank_s0   <= vid_blank;
            rgb_s0     <= vid_rgb;
            vs_prev    <= vs_s0;
            blank_prev <= blank_s0;
        end
    end

    assign vs_edge  = vs_prev & ~vs_s0;
    assign run_end  = blank_prev & ~blank_s0;
    // A VS edge restarts the coordinates before the same-cycle pixel is placed
    assign in_frame = (state == FRAME) || vs_edge;
    assign cur_x    = vs_edge ? '0 : x;
    assign cur_y    = vs_edge ? '0 : y;
    assign cur_base = vs_edge ? '0 : line_base;
    assign cur_addr = cur_base + (ADDR_W+1)'(cur_x);

    assign push      = in_frame && blank_s0 && (cur_x < X_MAX) && (cur_y < Y_MAX);
    assign pop       = out_valid && out_ready;
    assign ovf_set   = push && fifo_full && !pop;
    assign line_set  = (state == FRAME) && run_end && (run_len != RUN_FULL);
    assign frame_set = (state == FRAME) && vs_edge && (y != Y_MAX);

    always_comb begin
        wr_entry      = '0;
        wr_entry.addr = CAP_ADDR_W'(cur_addr[ADDR_W-1:0]);
        wr_entry.data = rgb_s0;
        wr_entry.sof  = (cur_addr == '0);
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state     <= HUNT;
            x         <= '0;
            y         <= '0;
            run_len   <= '0;
            line_base <= '0;
            frame_cnt <= '0;
        end else begin
            if (vs_edge) begin
                state <= FRAME;
                if ((state == FRAME) && (y == Y_MAX)) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end
            if (in_frame) begin
                if (blank_s0) begin
                    x         <= (cur_x < X_MAX) ? cur_x + 1'b1 : cur_x;
                    run_len   <= vs_edge ? RW'(1) :
                                 ((run_len < RUN_SAT) ? run_len + 1'b1 : run_len);
                    y         <= cur_y;
                    line_base <= cur_base;
                end else begin
                    x       <= '0;
                    run_len <= '0;
                    if (run_end && !vs_edge && (y < Y_MAX)) begin
                        y         <= y + 1'b1;
                        line_base <= line_base + LINE_STEP;
                    end else begin
                        y         <= cur_y;
                        line_base <= cur_base;
                    end
                end
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            ovf_err   <= 1'b0;
            line_err  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ovf_err   <= ovf_set   | (ovf_err   & ~clr_status);
            line_err  <= line_set  | (line_err  & ~clr_status);
            frame_err <= frame_set | (frame_err & ~clr_status);
        end
    end

    sync_fifo #(
        .WIDTH ($bits(cap_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (pixel_clk),
        .rst     (pixel_rst),
        .wr_en   (push),
        .wr_data (wr_entry),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (rd_entry),
        .empty   (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign out_addr  = rd_entry.addr[ADDR_W-1:0];
    assign out_data  = rd_entry.data;
    assign out_sof   = rd_entry.sof;

    // HS is sampled for later use only
    logic unused_ok;
    assign unused_ok = &{1'b0, hs_s0, rd_entry.addr};

endmodule
